// File: rtl/axi_lsu_master.sv
// Single-outstanding AXI4 initiator for the core load/store port.
// Each request becomes a single-beat INCR burst; the result is returned as a one-cycle response pulse.
module axi_lsu_master #(
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [31:0]     req_addr,
  input  logic [2:0]      req_size,
  input  logic [31:0]     req_wdata,
  input  logic [3:0]      req_wstrb,
  output logic            resp_valid,
  output logic [31:0]     resp_rdata,
  output logic            resp_err,
  output logic [31:0]     m_araddr,
  output logic            m_arvalid,
  output logic [ID_W-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  input  logic            m_arready,
  input  logic [31:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rvalid,
  input  logic            m_rlast,
  input  logic [ID_W-1:0] m_rid,
  output logic            m_rready,
  output logic [31:0]     m_awaddr,
  output logic            m_awvalid,
  output logic [ID_W-1:0] m_awid,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  input  logic            m_awready,
  output logic [31:0]     m_wdata,
  output logic [3:0]      m_wstrb,
  output logic            m_wvalid,
  output logic            m_wlast,
  input  logic            m_wready,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  input  logic [ID_W-1:0] m_bid,
  output logic            m_bready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [ID_W-1:0] ID_C = ID_W'(AXI_ID);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wen_q, wen_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        req_ready_q, req_ready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        resp_valid_q, resp_valid_d;

  logic ar_fire_s, r_fire_s, aw_fire_s, w_fire_s, b_fire_s;

  assign ar_fire_s = arvalid_q & m_arready;
  assign r_fire_s  = rready_q  & m_rvalid;
  assign aw_fire_s = awvalid_q & m_awready;
  assign w_fire_s  = wvalid_q  & m_wready;
  assign b_fire_s  = bready_q  & m_bvalid;

  // Next-state, request latching and response capture; channel controls decode from the next state.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    wen_d     = wen_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          wen_d     = req_wen;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_wen ? S_WREQ : S_RADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RADDR: begin
        if (ar_fire_s) begin
          state_d = S_RDATA;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RDATA: begin
        if (r_fire_s) begin
          rdata_d = m_rdata;
          err_d   = (m_rresp != 2'b00) | (m_rid != ID_C) | ~m_rlast;
          state_d = S_DONE;
        end else begin
          state_d = S_RDATA;
        end
      end
      S_WREQ: begin
        // AW and W complete independently, in either order or together.
        aw_done_d = aw_done_q | aw_fire_s;
        w_done_d  = w_done_q | w_fire_s;
        if (aw_done_d && w_done_d) begin
          state_d = S_WRESP;
        end else begin
          state_d = S_WREQ;
        end
      end
      S_WRESP: begin
        if (b_fire_s) begin
          err_d   = (m_bresp != 2'b00) | (m_bid != ID_C);
          state_d = S_DONE;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    arvalid_d    = (state_d == S_RADDR);
    rready_d     = (state_d == S_RDATA);
    awvalid_d    = (state_d == S_WREQ) & ~aw_done_d;
    wvalid_d     = (state_d == S_WREQ) & ~w_done_d;
    bready_d     = (state_d == S_WRESP);
    resp_valid_d = (state_d == S_DONE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      size_q       <= 3'd0;
      wstrb_q      <= 4'h0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      wen_q        <= wen_d;
      err_q        <= err_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  // Last read value is kept in rdata_q; a store response reports zero instead.
  assign resp_rdata = wen_q ? 32'h0 : rdata_q;
  assign resp_err   = err_q;

  assign m_araddr  = addr_q;
  assign m_arvalid = arvalid_q;
  assign m_arid    = ID_C;
  assign m_arlen   = 8'd0;
  assign m_arsize  = size_q;
  assign m_arburst = 2'b01;
  assign m_rready  = rready_q;

  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_awid    = ID_C;
  assign m_awlen   = 8'd0;
  assign m_awsize  = size_q;
  assign m_awburst = 2'b01;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wvalid_q;
  assign m_wlast   = wvalid_q;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_axi_lsu_master.sv
// Directed bench for axi_lsu_master: tasks play the core and the AXI responder,
// a negedge monitor pops the scoreboard on every resp_valid pulse.
module tb_axi_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [3:0]  m_arid, m_rid, m_awid, m_bid, m_wstrb;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;

  axi_lsu_master #(.ID_W(4), .AXI_ID(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arid(m_arid), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_rid(m_rid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bid(m_bid),
    .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int n_resp = 0;
  int n_exp = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_resp++;
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        if (e.exp_cyc >= 0) check("resp_latency", cyc, e.exp_cyc);
      end
    end
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err, input logic chk_lat);
    exp_t e;
    e.rdata   = rdata;
    e.err     = err;
    e.exp_cyc = chk_lat ? cyc + 3 : -1;
    sb.push_back(e);
    n_exp++;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input int ar_dly,
                         input int r_dly, input logic [31:0] rdata, input logic [1:0] rresp,
                         input logic [3:0] rid, input logic rlast, input logic exp_err,
                         input logic chk_lat);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_size = size;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    push_exp(rdata, exp_err, chk_lat);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_size = 3'd7;
    for (int k = 0; k <= ar_dly; k++) begin
      check("arvalid_hold", m_arvalid, 1'b1);
      check("araddr_stable", m_araddr, addr);
      check("arsize", m_arsize, size);
      check("req_ready_busy", req_ready, 1'b0);
      m_arready = (k == ar_dly);
      @(posedge clk); @(negedge clk);
    end
    m_arready = 1'b0;
    check("ar_len_burst", {m_arlen, m_arburst, m_arid}, {8'd0, 2'b01, 4'd0});
    for (int k = 0; k <= r_dly; k++) begin
      check("rready", m_rready, 1'b1);
      check("arvalid_off", m_arvalid, 1'b0);
      check("bready_off", m_bready, 1'b0);
      m_bvalid = (k < r_dly);
      m_rvalid = (k == r_dly);
      m_rdata = rdata; m_rresp = rresp; m_rid = rid; m_rlast = rlast;
      @(posedge clk); @(negedge clk);
    end
    m_rvalid = 1'b0; m_bvalid = 1'b0;
    check("req_ready_done", req_ready, 1'b0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] bresp,
                          input logic [3:0] bid, input logic exp_err, input logic chk_lat);
    int n;
    n = (aw_dly > w_dly) ? aw_dly : w_dly;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_size = 3'd2;
    req_wdata = wdata; req_wstrb = wstrb;
    push_exp(32'h0, exp_err, chk_lat);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 32'h0; req_wdata = ~wdata; req_wstrb = ~wstrb;
    for (int k = 0; k <= n; k++) begin
      check("awvalid", m_awvalid, (k <= aw_dly));
      check("wvalid", m_wvalid, (k <= w_dly));
      check("wlast", m_wlast, (k <= w_dly));
      check("bready_early", m_bready, 1'b0);
      check("aw_w_payload", {m_awaddr, m_wdata, m_wstrb, m_awlen}, {addr, wdata, wstrb, 8'd0});
      m_awready = (k == aw_dly);
      m_wready  = (k == w_dly);
      @(posedge clk); @(negedge clk);
    end
    m_awready = 1'b0; m_wready = 1'b0;
    for (int k = 0; k <= b_dly; k++) begin
      check("bready", m_bready, 1'b1);
      check("aw_w_off", {m_awvalid, m_wvalid}, 2'b00);
      m_bvalid = (k == b_dly); m_bresp = bresp; m_bid = bid;
      @(posedge clk); @(negedge clk);
    end
    m_bvalid = 1'b0;
    check("req_ready_done", req_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_size = 3'd0;
    req_wdata = 32'h0; req_wstrb = 4'h0;
    m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rid = 4'd0; m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    m_bid = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_valids", {req_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid},
          7'b1000000);
    check("reset_regs", {m_araddr, m_wdata, m_wstrb, resp_rdata, resp_err}, 101'd0);
    rst = 1'b0;

    do_load(32'h0000_1000, 3'd2, 0, 0, 32'hDEAD_BEEF, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1);
    do_load(32'h0000_2004, 3'd1, 5, 7, 32'hCAFE_F00D, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0);
    do_store(32'h8000_0004, 32'h1234_5678, 4'hF, 0, 2, 0, 2'b00, 4'd0, 1'b0, 1'b0);
    do_store(32'hA000_0048, 32'h0000_0055, 4'h1, 0, 0, 1, 2'b01, 4'd0, 1'b1, 1'b0);
    do_load(32'h0000_3000, 3'd2, 0, 0, 32'h1111_2222, 2'b00, 4'd3, 1'b1, 1'b1, 1'b1);
    do_load(32'h0000_3004, 3'd2, 1, 2, 32'h3333_4444, 2'b10, 4'd0, 1'b1, 1'b1, 1'b0);
    do_load(32'h0000_3008, 3'd0, 0, 1, 32'h5555_6666, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0);
    do_store(32'h0000_0010, 32'hA5A5_A5A5, 4'h3, 0, 0, 0, 2'b00, 4'd0, 1'b0, 1'b1);
    do_store(32'h0000_0020, 32'h0F0F_0F0F, 4'hC, 2, 0, 3, 2'b00, 4'd5, 1'b1, 1'b0);

    // Reset while RDATA has rvalid pending: no response may ever appear.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_4000; req_size = 3'd2;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; m_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_arready = 1'b0;
    check("rst_pre_rready", m_rready, 1'b1);
    m_rvalid = 1'b1; m_rdata = 32'h7777_8888; m_rresp = 2'b00; m_rid = 4'd0; m_rlast = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valids", {req_ready, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid},
          7'b1000000);
    @(posedge clk); @(negedge clk);
    m_rvalid = 1'b0;
    rst = 1'b0;

    do_load(32'h0000_000C, 3'd2, 0, 0, 32'h0BAD_F00D, 2'b00, 4'd0, 1'b1, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("resp_count", n_resp, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
